// File: rtl/shift_deserializer_16b.sv
// Serial-to-parallel frame collector with start/abort control and a
// valid/ready handshake on the completed word.
module shift_deserializer_16b #(
   parameter int WIDTH     = 16,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     r,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     sin,
   input  logic                     bit_en,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         Q,
   output logic                     out_valid,
   output logic                     busy,
   output logic [$clog2(WIDTH):0]   count,
   output logic                     overrun
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic             last_bit;

   always_comb begin
      sr_next  = LSB_FIRST ? {sin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sin};
      last_bit = (count == CW'(WIDTH - 1));
   end

   assign busy      = (state == SHIFT);
   assign out_valid = (state == HOLD);

   // Q is loaded only at frame completion so an abort or a partial frame
   // never disturbs the last delivered word.
   always_ff @(posedge clk or negedge r) begin
      if (!r) begin
         state   <= IDLE;
         sr      <= '0;
         Q       <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= SHIFT;
                  count   <= '0;
                  sr      <= '0;
                  overrun <= 1'b0;
               end else if (bit_en) begin
                  overrun <= 1'b1;
               end
            end
            SHIFT: begin
               if (abort) begin
                  state <= IDLE;
                  count <= '0;
               end else if (bit_en) begin
                  sr    <= sr_next;
                  count <= count + CW'(1);
                  if (last_bit) begin
                     Q     <= sr_next;
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready && start) begin
                  state   <= SHIFT;
                  count   <= '0;
                  sr      <= '0;
                  overrun <= 1'b0;
               end else begin
                  if (out_ready) state <= IDLE;
                  if (bit_en) overrun <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_deserializer_16b.sv
// Directed, table-driven bench for shift_deserializer_16b (LSB-first main
// instance plus an MSB-first instance sharing the same stimulus).
module tb_shift_deserializer_16b;

   logic        clk;
   logic        r;
   logic        start, abort, sin, bit_en, out_ready;
   logic [15:0] q1, q2;
   logic        v1, v2, b1, b2, o1, o2;
   logic [4:0]  c1, c2;

   shift_deserializer_16b #(.WIDTH(16), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .r(r), .start(start), .abort(abort), .sin(sin),
      .bit_en(bit_en), .out_ready(out_ready), .Q(q1), .out_valid(v1),
      .busy(b1), .count(c1), .overrun(o1)
   );

   shift_deserializer_16b #(.WIDTH(16), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .r(r), .start(start), .abort(abort), .sin(sin),
      .bit_en(bit_en), .out_ready(out_ready), .Q(q2), .out_valid(v2),
      .busy(b2), .count(c2), .overrun(o2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st, ab, s, be, rdy;
      logic [15:0] q;
      logic        v, b;
      logic [4:0]  c;
      logic        c_ck;
      logic        o;
      logic        q2_ck;
      logic [15:0] q2;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic void add(input logic st, ab, s, be, rdy,
                               input logic [15:0] q, input logic v, b,
                               input logic [4:0] c, input logic c_ck,
                               input logic o, input logic q2_ck,
                               input logic [15:0] q2v);
      vec_t t;
      t.st = st; t.ab = ab; t.s = s; t.be = be; t.rdy = rdy;
      t.q = q; t.v = v; t.b = b; t.c = c; t.c_ck = c_ck; t.o = o;
      t.q2_ck = q2_ck; t.q2 = q2v;
      vecs.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input string tag);
      start = t.st; abort = t.ab; sin = t.s; bit_en = t.be; out_ready = t.rdy;
      @(posedge clk);
      #1;
      chk({tag, " Q"}, 32'(q1), 32'(t.q));
      chk({tag, " out_valid"}, 32'(v1), 32'(t.v));
      chk({tag, " busy"}, 32'(b1), 32'(t.b));
      if (t.c_ck) chk({tag, " count"}, 32'(c1), 32'(t.c));
      chk({tag, " overrun"}, 32'(o1), 32'(t.o));
      if (t.q2_ck) chk({tag, " Q_msb"}, 32'(q2), 32'(t.q2));
   endtask

   initial begin
      logic [15:0] w;
      vec_t        t;

      // idle, then frame 0xA5C3 with a mid-frame start that must be ignored
      add(0,0,0,0,0, 16'h0000, 0,0, 5'd0, 1, 0, 0, 16'h0);
      add(1,0,0,0,0, 16'h0000, 0,1, 5'd0, 1, 0, 0, 16'h0);
      w = 16'hA5C3;
      for (int i = 0; i < 16; i++) begin
         if (i == 15)
            add(0,0,w[i],1,0, 16'hA5C3, 1,0, 5'd16, 1, 0, 1, 16'hC3A5);
         else
            add((i == 2),0,w[i],1,0, 16'h0000, 0,1, 5'(i+1), 1, 0, 0, 16'h0);
      end
      // HOLD with out_ready=0: start and abort have no effect
      for (int i = 0; i < 5; i++)
         add((i == 1 || i == 3),(i == 2),1,0,0, 16'hA5C3, 1,0, 5'd16, 1, 0, 0, 16'h0);
      // out_ready and start together: straight into a new frame
      add(1,0,0,0,1, 16'hA5C3, 0,1, 5'd0, 1, 0, 0, 16'h0);
      // 7 bits of 0x1234 then abort with bit_en high in the same cycle
      w = 16'h1234;
      for (int i = 0; i < 7; i++)
         add(0,0,w[i],1,0, 16'hA5C3, 0,1, 5'(i+1), 1, 0, 0, 16'h0);
      add(0,1,1,1,0, 16'hA5C3, 0,0, 5'd0, 1, 0, 0, 16'h0);
      // bit in IDLE sets overrun, which is sticky until the next start
      add(0,0,1,1,0, 16'hA5C3, 0,0, 5'd0, 1, 1, 0, 16'h0);
      add(0,0,0,0,0, 16'hA5C3, 0,0, 5'd0, 1, 1, 0, 16'h0);
      add(1,0,0,0,0, 16'hA5C3, 0,1, 5'd0, 1, 0, 0, 16'h0);
      // full 0x1234 frame with a 3-cycle bit_en gap after bit 8
      for (int i = 0; i < 16; i++) begin
         if (i == 8)
            for (int g = 0; g < 3; g++)
               add(0,0,~w[i],0,0, 16'hA5C3, 0,1, 5'd8, 1, 0, 0, 16'h0);
         if (i == 15)
            add(0,0,w[i],1,0, 16'h1234, 1,0, 5'd16, 1, 0, 1, 16'h2C48);
         else
            add(0,0,w[i],1,0, 16'hA5C3, 0,1, 5'(i+1), 1, 0, 0, 16'h0);
      end
      // bit during HOLD sets overrun, then release to IDLE
      add(0,0,1,1,0, 16'h1234, 1,0, 5'd16, 1, 1, 0, 16'h0);
      add(0,0,0,0,1, 16'h1234, 0,0, 5'd0, 0, 1, 0, 16'h0);
      add(0,0,0,0,0, 16'h1234, 0,0, 5'd0, 0, 1, 0, 16'h0);
      // new frame, 10 bits of 0xA5C3, then an asynchronous reset
      add(1,0,0,0,0, 16'h1234, 0,1, 5'd0, 1, 0, 0, 16'h0);
      w = 16'hA5C3;
      for (int i = 0; i < 10; i++)
         add(0,0,w[i],1,0, 16'h1234, 0,1, 5'(i+1), 1, 0, 0, 16'h0);

      r = 1'b0; start = 0; abort = 0; sin = 0; bit_en = 0; out_ready = 0;
      #2;
      chk("por Q", 32'(q1), 32'h0);
      chk("por out_valid", 32'(v1), 32'h0);
      chk("por busy", 32'(b1), 32'h0);
      chk("por count", 32'(c1), 32'h0);
      chk("por overrun", 32'(o1), 32'h0);
      #1 r = 1'b1;

      for (int k = 0; k < vecs.size(); k++)
         apply(vecs[k], $sformatf("vec%0d", k));

      // asynchronous reset between edges
      #1 r = 1'b0;
      #1;
      chk("arst Q", 32'(q1), 32'h0);
      chk("arst Q_msb", 32'(q2), 32'h0);
      chk("arst count", 32'(c1), 32'h0);
      chk("arst busy", 32'(b1), 32'h0);
      chk("arst out_valid", 32'(v1), 32'h0);
      chk("arst overrun", 32'(o1), 32'h0);
      start = 1'b1; bit_en = 1'b1;
      @(posedge clk);
      #1;
      chk("held busy", 32'(b1), 32'h0);
      chk("held count", 32'(c1), 32'h0);
      start = 1'b0; bit_en = 1'b0;
      r = 1'b1;
      t = '{st:0, ab:0, s:1, be:0, rdy:1, q:16'h0, v:0, b:0, c:5'd0,
            c_ck:1, o:0, q2_ck:1, q2:16'h0};
      for (int i = 0; i < 3; i++) apply(t, $sformatf("post%0d", i));
      // first edge after release starts a frame with no extra wait
      t.st = 1; t.b = 1;
      apply(t, "restart");
      t.st = 0; t.be = 1; t.c = 5'd1;
      apply(t, "restart_bit");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
